// File: rtl/ibex_zkn_aes_inv_subword.sv
`default_nettype none
// ============================================================================
// ibex_zkn_aes_inv_subword : serial AES InvSubBytes (one byte per cycle) with
// optional single-cycle InvMixColumns on a 32-bit column word.
// Revision: 1.0
// ============================================================================
module ibex_zkn_aes_inv_subword (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    input  logic        in_mix_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o
);

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] C_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_MIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_work;
    logic [1:0]  r_cnt;
    logic        r_mix;

    logic [7:0]  w_sub_in;
    logic [7:0]  w_sub_out;
    logic [7:0]  w_col [4];
    logic [31:0] w_mix;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    assign w_sub_in  = r_work[{r_cnt, 3'b000} +: 8];
    assign w_sub_out = C_INV_SBOX[11'd2040 - {w_sub_in, 3'b000} +: 8];

    for (genvar i = 0; i < 4; i++) begin : g_col
        assign w_col[i]          = r_work[8*i +: 8];
        assign w_mix[8*i +: 8]   = mul_e(w_col[i])
                                 ^ mul_b(w_col[(i + 1) % 4])
                                 ^ mul_d(w_col[(i + 2) % 4])
                                 ^ mul_9(w_col[(i + 3) % 4]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_mix   <= 1'b0;
        end else if (flush_i) begin
            // Abort discards the partial column so nothing stale is visible.
            r_state <= S_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_mix   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_work  <= in_data_i;
                        r_mix   <= in_mix_i;
                        r_cnt   <= '0;
                        r_state <= S_SUB;
                    end
                end
                S_SUB: begin
                    r_work[{r_cnt, 3'b000} +: 8] <= w_sub_out;
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= r_mix ? S_MIX : S_DONE;
                    end
                end
                S_MIX: begin
                    r_work  <= w_mix;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign out_data_o  = r_work;

endmodule
`default_nettype wire

// File: doc/ibex_zkn_aes_inv_subword.md
# ibex_zkn_aes_inv_subword

Iterative AES decryption-side column unit for the Zkn datapath: applies the AES inverse S-box (InvSubBytes) to each byte of a 32-bit column word, then optionally InvMixColumns. It reuses one inverse S-box lookup serially over four cycles to save area, and sits behind the crypto ALU operand registers. Valid/ready handshakes on both sides.

## Interface
- No parameters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous abort; returns the unit to IDLE.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  unit can accept a request.
- in_data_i  in  32  column word; byte k = bits [8k+7:8k], k=0 is row 0.
- in_mix_i  in  1  1: apply InvMixColumns after InvSubBytes.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- out_data_o  out  32  result word, same byte order as the input.

## Operation
- Inverse S-box: FIPS-197 inverse table (256 x 8-bit constant), indexed by the byte. Spot values: 00->52, 52->48, 63->00, 7C->01, 16->FF, ED->53.
- Registers:
  - 32-bit work register.
  - 2-bit byte counter.
  - Latched mix flag.
  - FSM state.
- FSM states:
  - IDLE: in_ready_o=1. If in_valid_i, load the work register with in_data_i, latch in_mix_i, set the counter to 0, and go to SUB.
  - SUB: replace work byte[cnt] with InvSbox(work byte[cnt]) and increment cnt. When cnt==3, go to MIX if the mix flag is set, else DONE.
  - MIX: replace the work register with InvMixColumns(work) in one cycle, then go to DONE.
    - For column bytes a0..a3, b_i = 0E·a_i ^ 0B·a_(i+1) ^ 0D·a_(i+2) ^ 09·a_(i+3), indices mod 4.
    - Multiplication is in GF(2^8) with polynomial 0x11B. xtime is a left shift with conditional XOR of 0x1B; the 8-bit width is preserved.
  - DONE: out_valid_o=1 and out_data_o=work. On out_ready_i go to IDLE. Otherwise hold, with out_data_o stable.
- in_ready_o is asserted only in IDLE; there is no same-cycle accept in DONE.
- in_data_i and in_mix_i are sampled only at acceptance; later changes have no effect.
- Priority:
  - rst_i wins over everything.
  - flush_i wins over the handshakes. In any state it forces IDLE, discards the work, and leaves out_valid_o low in the next cycle.
  - A request presented with flush_i high is not accepted.
- Reset values:
  - State IDLE, so in_ready_o=1.
  - out_valid_o=0, out_data_o=0 (work register cleared).
  - cnt=0, mix flag 0.
- Reset mid-operation drops the transaction immediately (asynchronous), with no output produced.

## Timing
- Accept at edge T0 (IDLE, in_valid_i=1).
- SUB occupies cycles T0+1..T0+4, i.e. four edges processing bytes 0,1,2,3.
- Without mix: out_valid_o is high from cycle T0+5; latency is 5 cycles from accept to valid.
- With mix: the MIX cycle is T0+5 and out_valid_o is high from cycle T0+6; latency is 6 cycles.
- The output handshake completes at the edge where out_valid_o && out_ready_i. The next request can be accepted one cycle later (IDLE).
- Maximum throughput is one column per 6 cycles (no mix) or 7 cycles (mix).
- The inverse S-box lookup and the InvMixColumns network each sit between registers; the path has a single 256-entry mux depth.

## Test plan
- Reset then idle: assert rst_i asynchronously mid-cycle -> immediately in_ready_o=1, out_valid_o=0, out_data_o=0x00000000.
- InvSubWord only: in_data_i=0x7C630052, in_mix_i=0 -> out_valid_o rises 5 cycles after accept with out_data_o=0x01005248; hold out_ready_i low 3 cycles -> data stable, in_ready_o=0.
- InvSub+InvMix, FIPS-197 column: in_data_i=0x6532E319, in_mix_i=1 -> intermediate 0xBCA14D8E, out_data_o=0x455313DB after 6 cycles.
- Full table sweep: 64 requests covering all 256 byte values, mix=0 -> every output byte matches the inverse table. Composing with the forward S-box returns the original byte.
- Flush in SUB at the second byte, with in_valid_i simultaneously high -> next cycle IDLE, no out_valid_o pulse, request not accepted. A following request of 0x16161616 -> 0xFFFFFFFF.
- Back-to-back: keep in_valid_i high with out_ready_i=1 -> accepts every 6 cycles, no result dropped or duplicated. Input changed after accept -> result reflects the accepted value.
